// File: rtl/frame_axis_sender.sv
// Store-and-forward AXI4-Stream sender. Buffers whole framed words and drops any
// frame that cannot fit, so only complete frames ever reach the stream.
module frame_axis_sender #(
    parameter int unsigned TDATA_WIDTH = 256,
    parameter int unsigned ADDR_WIDTH  = 6,
    parameter int unsigned CNT_WIDTH   = 16
) (
    input  logic                   CLK,
    input  logic                   RESETN,
    input  logic [TDATA_WIDTH-1:0] DIN,
    input  logic                   DIN_VALID,
    input  logic                   DIN_LAST,
    output logic [TDATA_WIDTH-1:0] M_AXIS_TDATA,
    output logic                   M_AXIS_TVALID,
    input  logic                   M_AXIS_TREADY,
    output logic                   M_AXIS_TLAST,
    output logic [CNT_WIDTH-1:0]   DROP_CNT,
    output logic [CNT_WIDTH-1:0]   FRAME_CNT,
    output logic [ADDR_WIDTH:0]    OCCUPANCY
);

    localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
    localparam int unsigned PTR_W = ADDR_WIDTH + 1;

    typedef struct packed {
        logic                   last;
        logic [TDATA_WIDTH-1:0] data;
    } word_t;

    typedef enum logic [0:0] {
        ACCEPT  = 1'b0,
        DISCARD = 1'b1
    } wstate_t;

    wstate_t          state;
    wstate_t          state_nxt;

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] commit_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr_nxt;
    logic [PTR_W-1:0] commit_ptr_nxt;
    logic [PTR_W-1:0] rd_ptr_nxt;
    logic [PTR_W-1:0] used;

    logic             full;
    logic             avail;
    logic             wr_en;
    logic             commit_en;
    logic             drop_evt;
    logic             load;
    logic             handshake;
    logic             tvalid_nxt;

    word_t            mem [DEPTH];
    word_t            rd_word;

    // Buffer status; the word parked in the output register is not part of used.
    assign used      = wr_ptr - rd_ptr;
    assign full      = (used == PTR_W'(DEPTH));
    assign avail     = (commit_ptr != rd_ptr);
    assign handshake = M_AXIS_TVALID & M_AXIS_TREADY;
    assign load      = avail & (~M_AXIS_TVALID | M_AXIS_TREADY);
    assign rd_word   = mem[rd_ptr[ADDR_WIDTH-1:0]];

    // Write FSM: state register
    always_ff @(posedge CLK) begin
        if (!RESETN) begin
            state <= ACCEPT;
        end else begin
            state <= state_nxt;
        end
    end

    // Write FSM: next state
    always_comb begin
        state_nxt = state;
        case (state)
            ACCEPT: begin
                if (DIN_VALID && full && !DIN_LAST) begin
                    state_nxt = DISCARD;
                end
            end
            DISCARD: begin
                if (DIN_VALID && DIN_LAST) begin
                    state_nxt = ACCEPT;
                end
            end
            default: state_nxt = ACCEPT;
        endcase
    end

    // Write FSM: per-cycle actions (store, commit, drop)
    always_comb begin
        wr_en     = 1'b0;
        commit_en = 1'b0;
        drop_evt  = 1'b0;
        if (RESETN && (state == ACCEPT) && DIN_VALID) begin
            if (full) begin
                drop_evt = 1'b1;
            end else begin
                wr_en     = 1'b1;
                commit_en = DIN_LAST;
            end
        end
    end

    // Pointer and output-valid next values; a drop rewinds to the last commit point
    always_comb begin
        wr_ptr_nxt     = wr_ptr;
        commit_ptr_nxt = commit_ptr;
        rd_ptr_nxt     = rd_ptr;
        tvalid_nxt     = M_AXIS_TVALID;
        if (drop_evt) begin
            wr_ptr_nxt = commit_ptr;
        end else if (wr_en) begin
            wr_ptr_nxt = wr_ptr + PTR_W'(1);
        end
        if (commit_en) begin
            commit_ptr_nxt = wr_ptr + PTR_W'(1);
        end
        if (load) begin
            rd_ptr_nxt = rd_ptr + PTR_W'(1);
            tvalid_nxt = 1'b1;
        end else if (handshake) begin
            tvalid_nxt = 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (wr_en) begin
            mem[wr_ptr[ADDR_WIDTH-1:0]] <= '{last: DIN_LAST, data: DIN};
        end
    end

    always_ff @(posedge CLK) begin
        if (!RESETN) begin
            wr_ptr     <= '0;
            commit_ptr <= '0;
            rd_ptr     <= '0;
        end else begin
            wr_ptr     <= wr_ptr_nxt;
            commit_ptr <= commit_ptr_nxt;
            rd_ptr     <= rd_ptr_nxt;
        end
    end

    // Output register holds data and last stable until the handshake
    always_ff @(posedge CLK) begin
        if (!RESETN) begin
            M_AXIS_TVALID <= 1'b0;
            M_AXIS_TDATA  <= '0;
            M_AXIS_TLAST  <= 1'b0;
        end else begin
            M_AXIS_TVALID <= tvalid_nxt;
            if (load) begin
                M_AXIS_TDATA <= rd_word.data;
                M_AXIS_TLAST <= rd_word.last;
            end
        end
    end

    // Occupancy counts buffered words plus the one held for the stream
    always_ff @(posedge CLK) begin
        if (!RESETN) begin
            OCCUPANCY <= '0;
        end else begin
            OCCUPANCY <= PTR_W'(wr_ptr_nxt - rd_ptr_nxt) + PTR_W'(tvalid_nxt);
        end
    end

    always_ff @(posedge CLK) begin
        if (!RESETN) begin
            DROP_CNT  <= '0;
            FRAME_CNT <= '0;
        end else begin
            if (drop_evt && (DROP_CNT != {CNT_WIDTH{1'b1}})) begin
                DROP_CNT <= DROP_CNT + CNT_WIDTH'(1);
            end
            if (handshake && M_AXIS_TLAST) begin
                FRAME_CNT <= FRAME_CNT + CNT_WIDTH'(1);
            end
        end
    end

endmodule

// File: tb/tb_frame_axis_sender.sv
// Self-checking bench for frame_axis_sender: table of fill/drain scenarios, latency,
// reset-mid-frame and random-backpressure sequences against a beat scoreboard.
module tb_frame_axis_sender;

    localparam int unsigned TW = 256;
    localparam int unsigned AW = 4;
    localparam int unsigned CW = 16;

    logic          CLK = 1'b0;
    logic          RESETN = 1'b0;
    logic [TW-1:0] DIN = '0;
    logic          DIN_VALID = 1'b0;
    logic          DIN_LAST = 1'b0;
    logic [TW-1:0] M_AXIS_TDATA;
    logic          M_AXIS_TVALID;
    logic          M_AXIS_TREADY = 1'b0;
    logic          M_AXIS_TLAST;
    logic [CW-1:0] DROP_CNT;
    logic [CW-1:0] FRAME_CNT;
    logic [AW:0]   OCCUPANCY;

    frame_axis_sender #(
        .TDATA_WIDTH(TW),
        .ADDR_WIDTH (AW),
        .CNT_WIDTH  (CW)
    ) dut (
        .CLK          (CLK),
        .RESETN       (RESETN),
        .DIN          (DIN),
        .DIN_VALID    (DIN_VALID),
        .DIN_LAST     (DIN_LAST),
        .M_AXIS_TDATA (M_AXIS_TDATA),
        .M_AXIS_TVALID(M_AXIS_TVALID),
        .M_AXIS_TREADY(M_AXIS_TREADY),
        .M_AXIS_TLAST (M_AXIS_TLAST),
        .DROP_CNT     (DROP_CNT),
        .FRAME_CNT    (FRAME_CNT),
        .OCCUPANCY    (OCCUPANCY)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic          last;
        logic [TW-1:0] data;
    } exp_t;

    typedef struct {
        int len0;
        int len1;
        bit acc0;
        bit acc1;
        int occ;
        int drop;
        int frames;
    } row_t;

    exp_t          exp_q[$];
    int            n_cmp = 0;
    int            n_bad = 0;
    bit            rnd_mode = 1'b0;
    bit            rnd_at_start = 1'b1;
    int            rnd_frames = 0;
    bit            prev_stall = 1'b0;
    logic [TW-1:0] prev_data = '0;
    logic          prev_last = 1'b0;

    task automatic chk(input string name, input logic [TW-1:0] act, input logic [TW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: event occurred, expected none", name);
    endtask

    // Output monitor: every handshake pops the scoreboard
    always @(negedge CLK) begin
        exp_t e;
        if (RESETN && M_AXIS_TVALID && M_AXIS_TREADY) begin
            if (rnd_mode && rnd_at_start) begin
                while (exp_q.size() > 0 && exp_q[0].data != M_AXIS_TDATA) void'(exp_q.pop_front());
                chk("rnd_frame_start", TW'(M_AXIS_TDATA[31:0] % 32'd6), TW'(0));
            end
            if (exp_q.size() == 0) begin
                fail_now("beat_unexpected");
            end else begin
                e = exp_q.pop_front();
                chk("beat_data", M_AXIS_TDATA, e.data);
                chk("beat_last", TW'(M_AXIS_TLAST), TW'(e.last));
            end
            if (rnd_mode) begin
                rnd_at_start = M_AXIS_TLAST;
                if (M_AXIS_TLAST) rnd_frames++;
            end
        end
        if (rnd_mode) begin
            if (prev_stall) begin
                chk("stall_tvalid", TW'(M_AXIS_TVALID), TW'(1));
                chk("stall_tdata", M_AXIS_TDATA, prev_data);
                chk("stall_tlast", TW'(M_AXIS_TLAST), TW'(prev_last));
            end
            prev_stall = M_AXIS_TVALID && !M_AXIS_TREADY;
            prev_data  = M_AXIS_TDATA;
            prev_last  = M_AXIS_TLAST;
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        RESETN = 1'b0;
        DIN_VALID = 1'b0;
        DIN_LAST = 1'b0;
        M_AXIS_TREADY = 1'b0;
        tick();
        tick();
        RESETN = 1'b1;
        exp_q.delete();
        rnd_at_start = 1'b1;
    endtask

    task automatic drive_word(input logic [TW-1:0] d, input logic last, input logic rdy);
        DIN = d;
        DIN_VALID = 1'b1;
        DIN_LAST = last;
        M_AXIS_TREADY = rdy;
        tick();
    endtask

    task automatic idle(input int n);
        DIN_VALID = 1'b0;
        DIN_LAST = 1'b0;
        repeat (n) tick();
    endtask

    // Drives one contiguous frame; words are scoreboarded only if it should survive
    task automatic send_frame(input int len, input int tag, input bit accepted, input logic rdy);
        logic [TW-1:0] d;
        for (int w = 0; w < len; w++) begin
            d = {32'($urandom), 192'(0), 16'(tag), 16'(w)};
            if (accepted) exp_q.push_back('{last: 1'(w == len - 1), data: d});
            drive_word(d, 1'(w == len - 1), rdy);
        end
        DIN_VALID = 1'b0;
        DIN_LAST = 1'b0;
    endtask

    task automatic drain(input string name, input bit rnd);
        bit done;
        done = 1'b0;
        for (int i = 0; i < 400 && !done; i++) begin
            M_AXIS_TREADY = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            tick();
            if (!M_AXIS_TVALID && OCCUPANCY == 0 && (rnd || exp_q.size() == 0)) done = 1'b1;
        end
        chk({name, "_drain_done"}, TW'(done), TW'(1));
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        row_t rows[5];
        int   cnt;
        logic [TW-1:0] d;

        // {len0, len1, acc0, acc1, occupancy after fill, drops, frames sent}
        rows[0] = '{8,  8, 1'b1, 1'b1, 16, 0, 2};
        rows[1] = '{10, 10, 1'b1, 1'b0, 10, 1, 1};
        rows[2] = '{20, 4, 1'b0, 1'b1, 4,  1, 1};
        rows[3] = '{17, 16, 1'b0, 1'b1, 16, 1, 1};
        rows[4] = '{16, 1, 1'b1, 1'b0, 16, 1, 1};

        do_reset();
        chk("rst_tvalid", TW'(M_AXIS_TVALID), TW'(0));
        chk("rst_tlast", TW'(M_AXIS_TLAST), TW'(0));
        chk("rst_tdata", M_AXIS_TDATA, TW'(0));
        chk("rst_drop", TW'(DROP_CNT), TW'(0));
        chk("rst_frame", TW'(FRAME_CNT), TW'(0));
        chk("rst_occ", TW'(OCCUPANCY), TW'(0));

        // Latency: header visible two cycles after footer, then 8 back-to-back beats
        M_AXIS_TREADY = 1'b1;
        send_frame(8, 100, 1'b1, 1'b1);
        @(negedge CLK);
        chk("t1_tvalid_t+1", TW'(M_AXIS_TVALID), TW'(0));
        for (int b = 0; b < 8; b++) begin
            @(negedge CLK);
            chk($sformatf("t1_beat%0d_tvalid", b), TW'(M_AXIS_TVALID), TW'(1));
        end
        @(negedge CLK);
        chk("t1_tvalid_after", TW'(M_AXIS_TVALID), TW'(0));
        chk("t1_frame_cnt", TW'(FRAME_CNT), TW'(1));
        chk("t1_occ", TW'(OCCUPANCY), TW'(0));
        chk("t1_sb_empty", TW'(exp_q.size()), TW'(0));
        tick();

        // Table: fill with TREADY low, check buffer state, then release and drain
        for (int r = 0; r < 5; r++) begin
            do_reset();
            send_frame(rows[r].len0, 2 * r, rows[r].acc0, 1'b0);
            send_frame(rows[r].len1, 2 * r + 1, rows[r].acc1, 1'b0);
            idle(3);
            chk($sformatf("row%0d_occ", r), TW'(OCCUPANCY), TW'(rows[r].occ));
            chk($sformatf("row%0d_drop", r), TW'(DROP_CNT), TW'(rows[r].drop));
            chk($sformatf("row%0d_tvalid", r), TW'(M_AXIS_TVALID), TW'(rows[r].acc0 | rows[r].acc1));
            drain($sformatf("row%0d", r), 1'b0);
            chk($sformatf("row%0d_frames", r), TW'(FRAME_CNT), TW'(rows[r].frames));
            chk($sformatf("row%0d_occ_end", r), TW'(OCCUPANCY), TW'(0));
        end

        // Reset mid-frame with two frames buffered and the writer discarding
        do_reset();
        send_frame(4, 200, 1'b1, 1'b1);
        drain("t6_pre", 1'b0);
        send_frame(8, 201, 1'b1, 1'b0);
        send_frame(8, 202, 1'b1, 1'b0);
        drive_word(TW'(32'hdead0000), 1'b0, 1'b0);
        drive_word(TW'(32'hdead0001), 1'b0, 1'b0);
        chk("t6_pre_drop", TW'(DROP_CNT), TW'(1));
        chk("t6_pre_frame", TW'(FRAME_CNT), TW'(1));
        RESETN = 1'b0;
        DIN = TW'(32'hdead0002);
        DIN_VALID = 1'b1;
        DIN_LAST = 1'b1;
        tick();
        RESETN = 1'b1;
        DIN_VALID = 1'b0;
        DIN_LAST = 1'b0;
        exp_q.delete();
        @(negedge CLK);
        chk("t6_tvalid", TW'(M_AXIS_TVALID), TW'(0));
        chk("t6_occ", TW'(OCCUPANCY), TW'(0));
        chk("t6_drop", TW'(DROP_CNT), TW'(0));
        chk("t6_frame", TW'(FRAME_CNT), TW'(0));
        tick();
        send_frame(5, 203, 1'b1, 1'b1);
        drain("t6_post", 1'b0);
        chk("t6_post_frame", TW'(FRAME_CNT), TW'(1));

        // Random backpressure with back-to-back 6-word counter frames
        do_reset();
        rnd_mode = 1'b1;
        rnd_frames = 0;
        prev_stall = 1'b0;
        cnt = 0;
        for (int f = 0; f < 200; f++) begin
            for (int w = 0; w < 6; w++) begin
                d = TW'(cnt);
                cnt++;
                exp_q.push_back('{last: 1'(w == 5), data: d});
                drive_word(d, 1'(w == 5), 1'($urandom_range(0, 1)));
            end
        end
        idle(1);
        drain("t5", 1'b1);
        chk("t5_frames_plus_drops", TW'(32'(FRAME_CNT) + 32'(DROP_CNT)), TW'(200));
        chk("t5_frames_seen", TW'(FRAME_CNT), TW'(rnd_frames));
        rnd_mode = 1'b0;
        exp_q.delete();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
